gate_selftest_ctrl: RTL
=======================

Name: gate_selftest_ctrl

Overview:
Built-in self-test sequencer for the two-input logic_gates unit. On a start pulse it drives the unit's a/b inputs through all four input vectors. After each vector it waits a settle interval, samples the seven gate outputs, and checks them against golden values. It reports per-vector pass/fail, a captured result log and a done/pass status. It sits between the unit and any system-level test/status logic.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15, 4-bit counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  synchronous abort of a running sweep
a_out  output  1  drives unit input a (registered)
b_out  output  1  drives unit input b (registered)
and_in  input  1  unit AND output
or_in  input  1  unit OR output
nor_in  input  1  unit NOR output
nand_in  input  1  unit NAND output
xor_in  input  1  unit XOR output
not_in  input  1  unit NOT output (NOT of a)
xnor_in  input  1  unit XNOR output
busy  output  1  high in SETTLE and SAMPLE
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  sweep result; valid from done until next start
fail_mask  output  4  bit v set if vector v mismatched
result_log  output  28  captured outputs, 7 bits per vector

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, cnt=0, and all outputs 0 (a_out, b_out, busy, done, pass, fail_mask, result_log).
- Vector order: idx v=0..3, a_out=v[0], b_out=v[1], giving ab = 00, 10, 01, 11.
- Observed word obs[6:0] = {xnor_in, not_in, xor_in, nand_in, nor_in, or_in, and_in}.
- Golden word per vector:
  - and = a&b, or = a|b, nor = ~(a|b), nand = ~(a&b)
  - xor = a^b, not = ~a, xnor = ~(a^b)
  - Packed in the same bit order as obs.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - Clear fail_mask, result_log and pass.
  - Set idx=0; drive vector 0; cnt=SETTLE_CYCLES-1; go to SETTLE.
  - a_out/b_out are 0 in IDLE.
- SETTLE: if cnt==0 go to SAMPLE, else cnt--. The vector is held for exactly SETTLE_CYCLES cycles before SAMPLE.
- SAMPLE, one cycle:
  - result_log[7*idx +: 7] <= obs.
  - fail_mask[idx] <= (obs != golden).
  - If idx==3: go to DONE.
  - Else: idx++, drive the next vector on the same edge, reload cnt, return to SETTLE.
- DONE, one cycle:
  - done=1 and pass=(fail_mask==0), both registered.
  - The final fail_mask bit written in SAMPLE is included.
  - Next state IDLE; a_out/b_out return to 0.
- Latency: done is high in the cycle 4*(SETTLE_CYCLES+1)+1 clock edges after the edge that samples start. This is 13 edges for the default.
- start while not IDLE: ignored; no restart, no effect on results.
- start in the DONE cycle: ignored. start in IDLE on the cycle after done: accepted.
- abort in SETTLE or SAMPLE:
  - Next state IDLE; a_out/b_out=0; done stays 0; pass=0.
  - fail_mask/result_log keep the values captured so far. The sample edge coinciding with abort is not captured.
  - abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins (abort is meaningless in IDLE).
- Reset mid-sweep: immediate return to reset values, no done pulse.
- pass, fail_mask and result_log are held stable in IDLE until the next accepted start.

Test Plan:
- Correct unit, SETTLE_CYCLES=2, start pulse -> done pulse exactly 13 edges later; pass=1; fail_mask=4'b0000; result_log=28'h86E8D6C (vectors 0..3 = 7'h6C, 7'h1A, 7'h3A, 7'h43); a/b sequence 00,10,01,11, each held 3 cycles.
- and_in forced 0 -> fail_mask=4'b1000, pass=0, result_log[27:21]=7'h42; not_in forced 1 -> fail_mask=4'b1010.
- start re-pulsed on cycles 3 and 8 of a running sweep -> identical timing and results to a single start; done pulses once.
- abort asserted during vector 2 SETTLE -> IDLE next cycle; a/b=00; done never asserts; pass=0; fail_mask bits 0..1 and result_log[13:0] hold captured values.
- rst asserted asynchronously mid-SAMPLE (between edges) -> all outputs 0 immediately; after release, a fresh start completes with pass=1.
- SETTLE_CYCLES=1 and 15 -> done at 9 and 65 edges after start respectively; results as in the first scenario.

Source files
------------

// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl
//   Built-in self-test sequencer for the two-input logic_gates unit. A start
//   pulse sweeps a/b through the four input vectors (ab = 00, 10, 01, 11).
//   Each vector is held SETTLE_CYCLES cycles, then the seven gate outputs are
//   sampled, logged and compared with the golden truth table.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a sweep (IDLE only) / cancel a running sweep
//   a_out, b_out        registered drive to the unit's a/b inputs
//   and_in .. xnor_in   the unit's seven gate outputs
//   busy                high while a vector is settling or being sampled
//   done                one-cycle pulse at the end of a completed sweep
//   pass                sweep result, valid from done until the next start
//   fail_mask           bit v set when vector v mismatched
//   result_log          observed 7-bit words, vector v at [7*v +: 7]
module gate_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        a_out,
  output logic        b_out,
  input  logic        and_in,
  input  logic        or_in,
  input  logic        nor_in,
  input  logic        nand_in,
  input  logic        xor_in,
  input  logic        not_in,
  input  logic        xnor_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_mask,
  output logic [27:0] result_log
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // SETTLE counts down to zero inclusive, so loading N-1 holds it N cycles.
  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_q, fail_d;
  logic [27:0] log_q, log_d;

  logic [6:0]  obs;
  logic [6:0]  golden;
  logic        vec_a, vec_b;
  logic [1:0]  idx_next;

  assign obs   = {xnor_in, not_in, xor_in, nand_in, nor_in, or_in, and_in};
  assign vec_a = idx_q[0];
  assign vec_b = idx_q[1];
  assign golden = {~(vec_a ^ vec_b), ~vec_a, vec_a ^ vec_b, ~(vec_a & vec_b),
                   ~(vec_a | vec_b), vec_a | vec_b, vec_a & vec_b};
  assign idx_next = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    log_d   = log_q;

    case (state_q)
      IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          fail_d  = '0;
          log_d   = '0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
        end else begin
          case (idx_q)
            2'd0:    log_d[6:0]   = obs;
            2'd1:    log_d[13:7]  = obs;
            2'd2:    log_d[20:14] = obs;
            default: log_d[27:21] = obs;
          endcase
          fail_d[idx_q] = (obs != golden);
          if (idx_q == 2'd3) begin
            state_d = DONE;
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            // Next vector is launched on the same edge that samples this one.
            idx_d   = idx_next;
            a_d     = idx_next[0];
            b_d     = idx_next[1];
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
          end
        end
      end

      default: begin
        // fail_q already holds the last vector's bit written by SAMPLE.
        done_d  = 1'b1;
        pass_d  = (fail_q == 4'd0);
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      log_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      log_q   <= log_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = fail_q;
  assign result_log = log_q;

endmodule
